// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI read channel (AR/R) between an instruction
// fetch master (M0) and a data load master (M1); one outstanding burst at a time.
module axi_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic [3:0]        m0_arlen,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rlast,
  output logic              m0_rvalid,
  input  logic              m0_rready,

  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic [3:0]        m1_arlen,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rlast,
  output logic              m1_rvalid,
  input  logic              m1_rready,

  output logic [ADDR_W-1:0] s_araddr,
  output logic [3:0]        s_arlen,
  output logic [ID_W-1:0]   s_arid,
  output logic              s_arvalid,
  input  logic              s_arready,
  input  logic [ID_W-1:0]   s_rid,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_rlast,
  input  logic              s_rvalid,
  output logic              s_rready,

  output logic              proto_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            grant_q, grant_d;
  logic            last_grant_q, last_grant_d;
  logic [3:0]      beat_cnt_q, beat_cnt_d;
  logic [3:0]      len_q, len_d;
  logic            proto_err_q, proto_err_d;

  logic            in_ar;
  logic            in_r;
  logic            beat;
  logic [ID_W-1:0] grant_id;

  assign in_ar    = (state_q == AR);
  assign in_r     = (state_q == R);
  assign grant_id = ID_W'(grant_q);

  // Address channel is driven only while a request is being presented.
  assign s_arvalid  = in_ar;
  assign s_araddr   = in_ar ? (grant_q ? m1_araddr : m0_araddr) : '0;
  assign s_arlen    = in_ar ? (grant_q ? m1_arlen  : m0_arlen)  : '0;
  assign s_arid     = in_ar ? grant_id : '0;
  assign m0_arready = in_ar & ~grant_q & s_arready;
  assign m1_arready = in_ar &  grant_q & s_arready;

  assign s_rready   = in_r & (grant_q ? m1_rready : m0_rready);
  assign m0_rvalid  = in_r & ~grant_q & s_rvalid;
  assign m1_rvalid  = in_r &  grant_q & s_rvalid;
  assign m0_rlast   = m0_rvalid & s_rlast;
  assign m1_rlast   = m1_rvalid & s_rlast;
  assign m0_rdata   = s_rdata;
  assign m1_rdata   = s_rdata;

  assign beat       = in_r & s_rvalid & s_rready;
  assign proto_err  = proto_err_q;

  always_comb begin
    // NOTE: every _d gets its hold value first so no path can leave one unassigned and infer a latch.
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    len_d        = len_q;
    proto_err_d  = proto_err_q;

    case (state_q)
      IDLE: begin
        if (m0_arvalid | m1_arvalid) begin
          grant_d    = (m0_arvalid & m1_arvalid) ? ~last_grant_q : m1_arvalid;
          len_d      = grant_d ? m1_arlen : m0_arlen;
          beat_cnt_d = '0;
          state_d    = AR;
        end
      end
      AR: begin
        if (s_arready) state_d = R;
      end
      R: begin
        if (beat) begin
          beat_cnt_d = beat_cnt_q + 4'd1;
          // rlast must coincide exactly with the beat whose index equals arlen.
          if ((s_rid != grant_id) || (s_rlast != (beat_cnt_q == len_q))) proto_err_d = 1'b1;
          if (s_rlast) begin
            last_grant_d = grant_q;
            state_d      = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      beat_cnt_q   <= '0;
      len_q        <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values computed above.
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      len_q        <= len_d;
      proto_err_q  <= proto_err_d;
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: directed scenarios plus randomized bursts
// against a round-robin / beat-count reference model.
module tb_axi_rd_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;

  logic clk = 1'b0;
  logic rst;

  logic [1:0][ADDR_W-1:0] m_araddr;
  logic [1:0][3:0]        m_arlen;
  logic [1:0]             m_arvalid;
  logic [1:0]             m_rready;
  wire  [1:0]             m_arready;
  wire  [1:0]             m_rlast;
  wire  [1:0]             m_rvalid;
  wire  [DATA_W-1:0]      m0_rdata, m1_rdata;

  wire  [ADDR_W-1:0]      s_araddr;
  wire  [3:0]             s_arlen;
  wire  [ID_W-1:0]        s_arid;
  wire                    s_arvalid;
  logic                   s_arready;
  logic [ID_W-1:0]        s_rid;
  logic [DATA_W-1:0]      s_rdata;
  logic                   s_rlast;
  logic                   s_rvalid;
  wire                    s_rready;
  wire                    proto_err;

  int vectors     = 0;
  int miscompares = 0;
  int last_g;      // model: master that completed the most recent burst
  bit exp_err;     // model: sticky protocol error

  always #5 clk = ~clk;

  axi_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .m0_araddr(m_araddr[0]), .m0_arlen(m_arlen[0]), .m0_arvalid(m_arvalid[0]),
    .m0_arready(m_arready[0]), .m0_rdata(m0_rdata), .m0_rlast(m_rlast[0]),
    .m0_rvalid(m_rvalid[0]), .m0_rready(m_rready[0]),
    .m1_araddr(m_araddr[1]), .m1_arlen(m_arlen[1]), .m1_arvalid(m_arvalid[1]),
    .m1_arready(m_arready[1]), .m1_rdata(m1_rdata), .m1_rlast(m_rlast[1]),
    .m1_rvalid(m_rvalid[1]), .m1_rready(m_rready[1]),
    .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arid(s_arid), .s_arvalid(s_arvalid),
    .s_arready(s_arready), .s_rid(s_rid), .s_rdata(s_rdata), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .proto_err(proto_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Round-robin rule: a lone requester wins; on a tie the master that did not go last wins.
  function automatic int pick();
    if (m_arvalid == 2'b11) return 1 - last_g;
    return m_arvalid[1] ? 1 : 0;
  endfunction

  task automatic pulse_reset();
    rst = 1'b1;
    s_arready = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0; s_rid = '0; s_rdata = '0;
    m_arvalid = 2'b00; m_rready = 2'b00;
    tick();
    rst = 1'b0;
    last_g  = 1;
    exp_err = 1'b0;
  endtask

  // Acts as the slave for one burst to master m: waits for the grant, handshakes the
  // address after ar_lat cycles, then returns beats 0..rlast_at (rlast on the final one).
  task automatic serve(input int m, input int rlast_at, input int bad_at, input int ar_lat,
                       input int gap, input int rr_mode, input bit keep,
                       input logic [DATA_W-1:0] data0, output int waited);
    int o, ph, cnt, g, lat, len;
    bit acc, last;
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] rd;
    o = 1 - m; ph = 0; waited = 0;
    len = int'(m_arlen[m]);
    lat = (ar_lat < 0) ? int'($urandom_range(0, 2)) : ar_lat;
    while (!s_arvalid && waited < 40) begin
      tick();
      waited++;
    end
    vectors++;
    if (s_arvalid !== 1'b1) begin
      miscompares++;
      $display("FAIL ar_timeout: s_arvalid=%b after %0d cycles, want 1", s_arvalid, waited);
      return;
    end
    vectors++;
    if (s_arid !== ID_W'(m) || s_araddr !== m_araddr[m] || s_arlen !== m_arlen[m]) begin
      miscompares++;
      $display("FAIL ar_mux: id=%0h addr=%h len=%0d, want id=%0h addr=%h len=%0d",
               s_arid, s_araddr, s_arlen, m, m_araddr[m], m_arlen[m]);
    end
    for (int i = 0; i <= lat; i++) begin
      s_arready = (i == lat);
      #1;
      vectors++;
      if (m_arready[m] !== s_arready || m_arready[o] !== 1'b0 || s_arvalid !== 1'b1) begin
        miscompares++;
        $display("FAIL ar_ready: arready=%b arvalid=%b, want granted=%b other=0 arvalid=1",
                 m_arready, s_arvalid, s_arready);
      end
      tick();
    end
    s_arready = 1'b0;
    if (keep) begin
      m_araddr[m] = $urandom;
      m_arlen[m]  = 4'($urandom_range(0, 3));
    end else begin
      m_arvalid[m] = 1'b0;
    end

    for (int b = 0; b <= rlast_at; b++) begin
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      s_rvalid = 1'b0;
      repeat (g) begin
        m_rready = 2'($urandom);
        #1;
        vectors++;
        if (m_rvalid !== 2'b00 || s_rready !== m_rready[m] || s_arvalid !== 1'b0) begin
          miscompares++;
          $display("FAIL r_gap: rvalid=%b s_rready=%b arvalid=%b, want rvalid=00 s_rready=%b arvalid=0",
                   m_rvalid, s_rready, s_arvalid, m_rready[m]);
        end
        tick();
      end
      d    = (b == 0 && data0 != '0) ? data0 : DATA_W'($urandom);
      last = (b == rlast_at);
      s_rvalid = 1'b1;
      s_rdata  = d;
      s_rlast  = last;
      s_rid    = (b == bad_at) ? ID_W'(m ^ (1 << $urandom_range(0, ID_W - 1))) : ID_W'(m);
      acc = 1'b0; cnt = 0;
      while (!acc && cnt < 20) begin
        case (rr_mode)
          0:       m_rready[m] = 1'b1;
          1:       m_rready[m] = (ph % 2 == 0);
          default: m_rready[m] = ($urandom_range(0, 3) != 0);
        endcase
        ph++;
        m_rready[o] = 1'($urandom);
        #1;
        rd = (m == 0) ? m0_rdata : m1_rdata;
        vectors++;
        if (m_rvalid[m] !== 1'b1 || m_rvalid[o] !== 1'b0 || s_rready !== m_rready[m] ||
            rd !== d || m_rlast[m] !== last || m_rlast[o] !== 1'b0 || m_arready !== 2'b00) begin
          miscompares++;
          $display("FAIL r_beat%0d: m%0d rvalid=%b rlast=%b data=%h s_rready=%b arready=%b, want rvalid=1 rlast=%b data=%h s_rready=%b other quiet",
                   b, m, m_rvalid[m], m_rlast[m], rd, s_rready, m_arready, last, d, m_rready[m]);
        end
        acc = m_rready[m];
        cnt++;
        tick();
      end
      vectors++;
      if (!acc) begin
        miscompares++;
        $display("FAIL r_timeout: beat %0d never accepted, want acceptance", b);
        s_rvalid = 1'b0;
        return;
      end
      if (s_rid != ID_W'(m) || last != ((b % 16) == len)) exp_err = 1'b1;
    end
    last_g = m;
    // Stale s_rvalid stays high for this check: the block must already be back in IDLE.
    vectors++;
    if (m_rvalid !== 2'b00 || s_rready !== 1'b0 || s_arvalid !== 1'b0 || proto_err !== exp_err) begin
      miscompares++;
      $display("FAIL r_done: rvalid=%b s_rready=%b arvalid=%b proto_err=%b, want 00 0 0 %b",
               m_rvalid, s_rready, s_arvalid, proto_err, exp_err);
    end
    s_rvalid = 1'b0;
    s_rlast  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_arready = 1'b0; s_rvalid = 1'b1; s_rlast = 1'b1; s_rid = '0; s_rdata = '0;
    m_araddr = '1; m_arlen = '1; m_arvalid = 2'b11; m_rready = 2'b11;
    repeat (3) tick();
    vectors++;
    if ({s_arvalid, s_rready, m_arready, m_rvalid, m_rlast, proto_err} !== 8'h00 ||
        s_araddr !== '0 || s_arlen !== '0 || s_arid !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: arvalid=%b rready=%b arready=%b rvalid=%b rlast=%b err=%b addr=%h len=%0d id=%0h, want all 0",
               s_arvalid, s_rready, m_arready, m_rvalid, m_rlast, proto_err, s_araddr, s_arlen, s_arid);
    end
    s_rvalid = 1'b0; s_rlast = 1'b0; m_arvalid = 2'b00; m_rready = 2'b00;
    rst = 1'b0;
    last_g = 1; exp_err = 1'b0;
    tick();
  endtask

  task automatic test_single_m0();
    int w;
    m_araddr[0] = 32'hBFC0_0000;
    m_arlen[0]  = 4'd0;
    m_arvalid[0] = 1'b1;
    serve(0, 0, -1, 1, 2, 0, 1'b0, 32'h3C08_BFC0, w);
    vectors++;
    if (w != 1) begin
      miscompares++;
      $display("FAIL single_grant_latency: %0d cycles, want 1", w);
    end
  endtask

  task automatic test_simultaneous();
    int w, l0, l1;
    pulse_reset();
    m_araddr[0] = $urandom; m_arlen[0] = 4'($urandom_range(0, 3));
    m_araddr[1] = $urandom; m_arlen[1] = 4'($urandom_range(0, 3));
    l0 = int'(m_arlen[0]); l1 = int'(m_arlen[1]);
    m_arvalid = 2'b11;
    serve(0, l0, -1, -1, -1, 0, 1'b0, '0, w);
    serve(1, l1, -1, -1, -1, 0, 1'b0, '0, w);
    vectors++;
    if (w != 1) begin
      miscompares++;
      $display("FAIL simul_m1_grant: m1 granted %0d cycles after m0 rlast, want 1", w);
    end
  endtask

  task automatic test_fairness();
    int w, l;
    m_araddr[0] = $urandom; m_arlen[0] = 4'($urandom_range(0, 3));
    m_araddr[1] = $urandom; m_arlen[1] = 4'($urandom_range(0, 3));
    m_arvalid = 2'b11;
    for (int i = 0; i < 6; i++) begin
      l = int'(m_arlen[i % 2]);
      serve(i % 2, l, -1, -1, -1, 2, 1'b1, '0, w);
    end
    m_arvalid = 2'b00;
  endtask

  task automatic test_backpressure();
    int w;
    m_araddr[1] = $urandom;
    m_arlen[1]  = 4'd3;
    m_arvalid[1] = 1'b1;
    serve(1, 3, -1, 0, 0, 1, 1'b0, '0, w);
  endtask

  task automatic test_errors();
    int w;
    pulse_reset();
    m_araddr[0] = $urandom; m_arlen[0] = 4'd1; m_arvalid[0] = 1'b1;
    serve(0, 0, -1, -1, -1, 0, 1'b0, '0, w);
    vectors++;
    if (proto_err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_early_rlast: proto_err=%b, want 1", proto_err);
    end
    m_arlen[0] = 4'd2; m_arvalid[0] = 1'b1;
    serve(0, 2, -1, -1, -1, 0, 1'b0, '0, w);
    vectors++;
    if (proto_err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_sticky: proto_err=%b after clean burst, want 1", proto_err);
    end
    pulse_reset();
    m_arlen[0] = 4'd0; m_arvalid[0] = 1'b1;
    serve(0, 0, 0, -1, -1, 0, 1'b0, '0, w);
    vectors++;
    if (proto_err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_bad_rid: proto_err=%b, want 1", proto_err);
    end
  endtask

  task automatic test_reset_mid_burst();
    int w;
    pulse_reset();
    m_araddr[1] = $urandom; m_arlen[1] = 4'd3; m_arvalid[1] = 1'b1;
    tick();
    s_arready = 1'b1;
    tick();
    s_arready = 1'b0; m_arvalid[1] = 1'b0;
    s_rvalid = 1'b1; s_rlast = 1'b0; s_rid = 4'h9; s_rdata = $urandom; m_rready = 2'b11;
    tick();
    vectors++;
    if (m_rvalid[1] !== 1'b1 || proto_err !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_burst_setup: m1_rvalid=%b proto_err=%b, want 1 1", m_rvalid[1], proto_err);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({s_arvalid, s_rready, m_arready, m_rvalid, m_rlast, proto_err} !== 8'h00 ||
        s_araddr !== '0 || s_arlen !== '0 || s_arid !== '0) begin
      miscompares++;
      $display("FAIL async_reset: arvalid=%b rready=%b arready=%b rvalid=%b rlast=%b err=%b, want all 0",
               s_arvalid, s_rready, m_arready, m_rvalid, m_rlast, proto_err);
    end
    tick();
    rst = 1'b0; s_rvalid = 1'b0; s_rid = '0;
    last_g = 1; exp_err = 1'b0;
    m_araddr[0] = $urandom; m_arlen[0] = 4'd1;
    m_araddr[1] = $urandom; m_arlen[1] = 4'd0;
    m_arvalid = 2'b11;
    serve(0, 1, -1, -1, -1, 0, 1'b0, '0, w);
    vectors++;
    if (w != 1) begin
      miscompares++;
      $display("FAIL post_reset_grant: %0d cycles to grant, want 1", w);
    end
    serve(1, 0, -1, -1, -1, 0, 1'b0, '0, w);
  endtask

  task automatic test_random();
    int w, m, len, kind, rl, bad, k;
    for (int it = 0; it < 40; it++) begin
      for (int q = 0; q < 2; q++) begin
        if (!m_arvalid[q] && $urandom_range(0, 1) == 1) begin
          m_arvalid[q] = 1'b1;
          m_araddr[q]  = $urandom;
          m_arlen[q]   = 4'($urandom_range(0, 15));
        end
      end
      if (m_arvalid == 2'b00) begin
        k = int'($urandom_range(0, 1));
        m_arvalid[k] = 1'b1;
        m_araddr[k]  = $urandom;
        m_arlen[k]   = 4'($urandom_range(0, 15));
      end
      m    = pick();
      len  = int'(m_arlen[m]);
      kind = int'($urandom_range(0, 9));
      rl   = len;
      bad  = -1;
      if (kind == 0) bad = int'($urandom_range(0, len));
      else if (kind == 1 && len > 0) rl = int'($urandom_range(0, len - 1));
      else if (kind == 2) rl = len + 1;
      serve(m, rl, bad, -1, -1, 2, 1'($urandom_range(0, 1)), '0, w);
      vectors++;
      if (w != 1) begin
        miscompares++;
        $display("FAIL rand_grant_latency it%0d: %0d cycles, want 1", it, w);
      end
    end
    m_arvalid = 2'b00;
  endtask

  initial begin
    test_reset();
    test_single_m0();
    test_simultaneous();
    test_fairness();
    test_backpressure();
    test_errors();
    test_reset_mid_burst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, want completion");
    $fatal(1);
  end

endmodule
